// File: rtl/mimo_pkg.sv
// Shared definitions for the MIMO detector datapath: FSM states, default radicand
// width and helpers deriving the root width and cycle count.
package mimo_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_e;

    localparam int DEF_IN_W = 56;

    function automatic int calc_q_w(input int in_w);
        return in_w / 2;
    endfunction

    function automatic int calc_n_cyc(input int in_w, input int iter_per_cyc);
        return (in_w / 2) / iter_per_cyc;
    endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// Operand/result handshake bundle for sqrt_seq; the producer/consumer side uses
// master, the root unit uses slave.
interface sqrt_seq_if
    import mimo_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
);
    localparam int Q_W = calc_q_w(IN_W);

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] num;
    logic            out_valid;
    logic            out_ready;
    logic [Q_W-1:0]  sqrt;
    logic [Q_W:0]    rem;

    modport master (output in_valid, num, out_ready,
                    input  in_ready, out_valid, sqrt, rem);
    modport slave  (input  in_valid, num, out_ready,
                    output in_ready, out_valid, sqrt, rem);
endinterface

// File: rtl/sqrt_nr_step.sv
// One combinational non-restoring square-root iteration: consumes the next two
// radicand bits and produces the next partial remainder and root.
module sqrt_nr_step #(
    parameter int Q_W = 28
) (
    input  logic [Q_W+1:0] i_r,
    input  logic [Q_W-1:0] i_q,
    input  logic [1:0]     i_d,
    output logic [Q_W+1:0] o_r,
    output logic [Q_W-1:0] o_q
);
    logic [Q_W+1:0] w_left;
    logic [Q_W+1:0] w_right;
    logic           w_neg;
    logic           w_unused;

    assign w_neg   = i_r[Q_W+1];
    assign w_left  = {i_r[Q_W-1:0], i_d};
    assign w_right = {i_q, w_neg, 1'b1};
    assign o_r     = w_neg ? (w_left + w_right) : (w_left - w_right);
    assign o_q     = {i_q[Q_W-2:0], ~o_r[Q_W+1]};
    // bit Q_W is shifted out; only the sign bit above it survives the step
    assign w_unused = i_r[Q_W];
endmodule

// File: rtl/sqrt_seq.sv
// Multi-cycle integer square root (floor root + remainder), ITER_PER_CYC bits per
// clock. Define SQRT_ROUND_EN to round the root to nearest (saturating).
module sqrt_seq
    import mimo_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int ITER_PER_CYC = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    sqrt_seq_if.slave  bus
);
    localparam int Q_W   = calc_q_w(IN_W);
    localparam int N_CYC = calc_n_cyc(IN_W, ITER_PER_CYC);
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;

    sqrt_state_e      r_state, w_nxt;
    logic [IN_W-1:0]  r_d;
    logic [Q_W-1:0]   r_q;
    logic [Q_W+1:0]   r_r;
    logic [CNT_W-1:0] r_cnt;
    logic [Q_W-1:0]   r_sqrt;
    logic [Q_W:0]     r_rem;

    logic [ITER_PER_CYC:0][Q_W+1:0] w_r;
    logic [ITER_PER_CYC:0][Q_W-1:0] w_q;
    logic [Q_W+1:0] w_r_fin;
    logic [Q_W-1:0] w_q_fin;
    logic [Q_W:0]   w_rem;
    logic [Q_W-1:0] w_sqrt;
    logic           w_last;
    logic           w_in_ready;
    logic           w_out_valid;

    assign w_r[0] = r_r;
    assign w_q[0] = r_q;

    for (genvar g = 0; g < ITER_PER_CYC; g++) begin : g_step
        sqrt_nr_step #(.Q_W(Q_W)) u_step (
            .i_r (w_r[g]),
            .i_q (w_q[g]),
            .i_d (r_d[IN_W-1-2*g -: 2]),
            .o_r (w_r[g+1]),
            .o_q (w_q[g+1])
        );
    end

    assign w_r_fin = w_r[ITER_PER_CYC];
    assign w_q_fin = w_q[ITER_PER_CYC];
    assign w_last  = (r_cnt == CNT_W'(N_CYC - 1));

    // Corrected remainder is in [0, 2q], so Q_W+1 bits of the sum are exact.
    assign w_rem = w_r_fin[Q_W+1] ? (w_r_fin[Q_W:0] + {w_q_fin, 1'b1}) : w_r_fin[Q_W:0];

`ifdef SQRT_ROUND_EN
    assign w_sqrt = (w_rem > {1'b0, w_q_fin})
                  ? ((&w_q_fin) ? w_q_fin : w_q_fin + Q_W'(1))
                  : w_q_fin;
`else
    assign w_sqrt = w_q_fin;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_nxt = CALC;
            end
            CALC: if (w_last) w_nxt = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d    <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_sqrt <= '0;
            r_rem  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_d   <= bus.num;
                    r_q   <= '0;
                    r_r   <= '0;
                    r_cnt <= '0;
                end
                CALC: begin
                    r_d   <= r_d << (2 * ITER_PER_CYC);
                    r_q   <= w_q_fin;
                    r_r   <= w_r_fin;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sqrt <= w_sqrt;
                        r_rem  <= w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sqrt      = r_sqrt;
    assign bus.rem       = r_rem;
endmodule

// File: tb/tb_sqrt_seq.sv
// Directed checks of sqrt_seq: exact roots, rounding, max input, handshake hold,
// mid-operation reset, ITER_PER_CYC=2 latency and a 16-bit random sweep.
module tb_sqrt_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sqrt_seq_if #(.IN_W(56)) bus  ();
    sqrt_seq_if #(.IN_W(56)) bus2 ();
    sqrt_seq_if #(.IN_W(16)) bus3 ();

    sqrt_seq #(.IN_W(56), .ITER_PER_CYC(1)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
    sqrt_seq #(.IN_W(56), .ITER_PER_CYC(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    sqrt_seq #(.IN_W(16), .ITER_PER_CYC(1)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

`ifdef SQRT_ROUND_EN
    localparam logic [63:0] EXP157 = 64'd13;
`else
    localparam logic [63:0] EXP157 = 64'd12;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [63:0] n, input logic ordy);
        case (w)
            0: begin bus.in_valid  = v; bus.num  = n[55:0]; bus.out_ready  = ordy; end
            1: begin bus2.in_valid = v; bus2.num = n[55:0]; bus2.out_ready = ordy; end
            default: begin bus3.in_valid = v; bus3.num = n[15:0]; bus3.out_ready = ordy; end
        endcase
    endtask

    function automatic logic get_ov(input int w);
        case (w)
            0: return bus.out_valid;
            1: return bus2.out_valid;
            default: return bus3.out_valid;
        endcase
    endfunction

    function automatic logic [63:0] get_s(input int w);
        case (w)
            0: return 64'(bus.sqrt);
            1: return 64'(bus2.sqrt);
            default: return 64'(bus3.sqrt);
        endcase
    endfunction

    function automatic logic [63:0] get_r(input int w);
        case (w)
            0: return 64'(bus.rem);
            1: return 64'(bus2.rem);
            default: return 64'(bus3.rem);
        endcase
    endfunction

    function automatic logic [63:0] rnd(input logic [63:0] fl, input logic [63:0] rm,
                                        input logic [63:0] maxv);
`ifdef SQRT_ROUND_EN
        return (rm > fl) ? ((fl == maxv) ? fl : fl + 64'd1) : fl;
`else
        return (rm > maxv) ? fl : fl;
`endif
    endfunction

    task automatic start(input int w, input logic [63:0] n);
        @(negedge clk);
        drive(w, 1'b1, n, 1'b0);
        @(posedge clk); #1;
        drive(w, 1'b0, n, 1'b0);
    endtask

    task automatic wait_res(input int w, output int lat);
        lat = 0;
        while (!get_ov(w) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_res(input int w);
        @(negedge clk);
        drive(w, 1'b0, 64'd0, 1'b1);
        @(posedge clk); #1;
        drive(w, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic op(input int w, input logic [63:0] n, output logic [63:0] s,
                      output logic [63:0] r, output int lat);
        start(w, n);
        wait_res(w, lat);
        s = get_s(w);
        r = get_r(w);
        release_res(w);
    endtask

    initial begin
        logic [63:0] s, r, n, es, er;
        int lat;
        drive(0, 1'b0, 64'd0, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b0);
        drive(2, 1'b0, 64'd0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sqrt",      64'(bus.sqrt),      64'd0);
        chk("rst_rem",       64'(bus.rem),       64'd0);

        op(0, 64'd144, s, r, lat);
        chk("lat_144", 64'(lat), 64'd28); chk("sqrt_144", s, 64'd12); chk("rem_144", r, 64'd0);
        op(0, 64'd156, s, r, lat);
        chk("sqrt_156", s, 64'd12); chk("rem_156", r, 64'd12);
        op(0, 64'd0, s, r, lat);
        chk("lat_0", 64'(lat), 64'd28); chk("sqrt_0", s, 64'd0); chk("rem_0", r, 64'd0);
        op(0, 64'd157, s, r, lat);
        chk("sqrt_157", s, EXP157); chk("rem_157", r, 64'd13);
        op(0, 64'h00FF_FFFF_FFFF_FFFF, s, r, lat);
        chk("sqrt_max", s, 64'd268435455); chk("rem_max", r, 64'd536870910);

        // result held while the consumer stalls
        start(0, 64'd200);
        wait_res(0, lat);
        chk("lat_200", 64'(lat), 64'd28);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_sqrt",     64'(bus.sqrt),      64'd14);
            chk("hold_rem",      64'(bus.rem),       64'd4);
            chk("hold_in_ready", 64'(bus.in_ready),  64'd0);
            chk("hold_valid",    64'(bus.out_valid), 64'd1);
        end
        release_res(0);
        chk("rel_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // in_valid pulse and num change during CALC are ignored
        start(0, 64'd100);
        @(negedge clk);
        chk("calc_in_ready", 64'(bus.in_ready), 64'd0);
        drive(0, 1'b1, 64'd49, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 64'd49, 1'b0);
        wait_res(0, lat);
        chk("lat_100",  64'(lat + 1), 64'd28);
        chk("sqrt_100", get_s(0), 64'd10);
        chk("rem_100",  get_r(0), 64'd0);
        release_res(0);

        // reset at CALC cycle 5 aborts the operation
        start(0, 64'h0000_0100_0000_0000);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk) rst = 1'b0;
        op(0, 64'd81, s, r, lat);
        chk("lat_81", 64'(lat), 64'd28); chk("sqrt_81", s, 64'd9); chk("rem_81", r, 64'd0);

        // two iterations per cycle
        op(1, 64'd157, s, r, lat);
        chk("ipc2_lat", 64'(lat), 64'd14); chk("ipc2_sqrt", s, EXP157); chk("ipc2_rem", r, 64'd13);
        op(1, 64'h00FF_FFFF_FFFF_FFFF, s, r, lat);
        chk("ipc2_sqrt_max", s, 64'd268435455); chk("ipc2_rem_max", r, 64'd536870910);

        // 16-bit radicand: boundary then random sweep against a brute-force root
        op(2, 64'd65535, s, r, lat);
        chk("w16_lat", 64'(lat), 64'd8); chk("w16_sqrt_max", s, 64'd255); chk("w16_rem_max", r, 64'd510);
        for (int k = 0; k < 1000; k++) begin
            n  = 64'($urandom_range(0, 65535));
            es = 64'd0;
            while ((es + 64'd1) * (es + 64'd1) <= n) es++;
            er = n - es * es;
            op(2, n, s, r, lat);
            chk("w16_sqrt", s, rnd(es, er, 64'd255));
            chk("w16_rem",  r, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_seq.md
# sqrt_seq

Parametrised, multi-cycle integer square-root unit for the QR-based MIMO detector datapath, the sequential successor of the combinational non-restoring root.
- Computes floor(sqrt(num)) and the remainder over Q_W/ITER_PER_CYC clock cycles, resolving ITER_PER_CYC result bits per cycle.
- Valid/ready handshakes on both sides let it sit between the column-norm accumulator and the R-diagonal/normalisation stage without a long combinational path.

## Interface
- IN_W, 56: radicand width. Must be even and ≥ 4.
- ITER_PER_CYC, 1: non-restoring iterations per clock. Must divide IN_W/2.
- Derived: Q_W = IN_W/2; N_CYC = Q_W/ITER_PER_CYC.
- clk  in  1  single clock; all registers on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  num is valid.
- in_ready  out  1  block can accept an operand.
- num  in  IN_W  unsigned radicand.
- out_valid  out  1  sqrt/rem valid.
- out_ready  in  1  consumer accepts result.
- sqrt  out  Q_W  root (floor, or rounded with SQRT_ROUND_EN).
- rem  out  Q_W+1  num − floor_root², always the floor remainder.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch num into the shift register, clear q and r, zero the iteration counter, go to CALC.
  - CALC: in_ready=0. Perform ITER_PER_CYC non-restoring steps per cycle and increment the counter. On the cycle the counter reaches N_CYC−1, apply the final correction and register sqrt/rem, then go to DONE.
  - DONE: out_valid=1, with sqrt/rem held stable. On out_ready, go to IDLE.
- Non-restoring step, with partial remainder r of Q_W+2 bits in two's complement:
  - left = {r[Q_W−1:0], next two radicand MSBs}
  - right = {q, r[MSB], 1}
  - If r is negative, r = left + right; otherwise r = left − right.
  - Shift q left by one and insert !r[MSB].
- Final correction: if r is negative, rem = r + {q,1}; otherwise rem = r. The rem output is never negative.
- Arithmetic is unsigned on the input and two's complement internally. No width truncation of the remainder occurs before the correction.
- in_ready and out_valid are never both high.
- A new operand is not accepted in the cycle the result is consumed. Throughput is one result per N_CYC+2 cycles.

## Timing
- Reset values: in_ready=1 after the first post-reset cycle (state IDLE), out_valid=0, sqrt=0, rem=0. The counter, q and r are cleared.
- rst overrides all inputs. Asserting rst during CALC or DONE discards the operation and returns to IDLE on that edge. No spurious out_valid.
- Accept edge E0 (in_valid & in_ready). CALC covers edges E1..E_N_CYC. out_valid is high after edge E_N_CYC, giving a latency of N_CYC cycles from the accept edge. IN_W=56, ITER_PER_CYC=1 gives 28 cycles.
- in_valid while not ready is ignored, and num is not sampled. The producer must hold the operand.
- out_ready low: remain in DONE indefinitely with outputs held.
- num changing during CALC has no effect.

## Configuration
- SQRT_ROUND_EN defined: sqrt = floor_root + 1 when rem > floor_root (round to nearest, ties impossible for integers). The result saturates to all-ones if the increment would overflow Q_W bits. The comparator and incrementer are added to the final-correction cycle; latency is unchanged.
- SQRT_ROUND_EN undefined: sqrt = floor_root. No comparator or incrementer is present.
- rem is identical in both builds.

## Structure
- Shared package mimo_pkg holds:
  - the FSM state enum (IDLE, CALC, DONE)
  - the default IN_W (56)
  - the function computing Q_W and N_CYC
- One sub-module, sqrt_nr_step. It is combinational: a single non-restoring iteration taking {r, q, radicand pair} and returning the next {r, q}. It is instantiated ITER_PER_CYC times in a generate chain inside sqrt_seq.

## Test plan
- Exactness, IN_W=56: num=144 → sqrt=12, rem=0. num=156 → sqrt=12, rem=12. num=0 → sqrt=0, rem=0. out_valid appears exactly 28 cycles after the accept edge.
- Rounding: num=157 → floor 12, rem=13. With SQRT_ROUND_EN, sqrt=13; without it, sqrt=12. num=156 → 12 in both builds.
- Max input: num=2^56−1 → floor 268435455, rem=536870910. The SQRT_ROUND_EN build saturates sqrt to 268435455.
- Handshake: hold out_ready=0 for 10 cycles after the result; outputs stay stable and in_ready=0. Pulse in_valid during CALC; it is ignored.
- Reset mid-operation: assert rst at CALC cycle 5. Next cycle out_valid=0 and in_ready=1. A fresh operand num=81 then yields sqrt=9, rem=0.
- Configuration sweep: ITER_PER_CYC=2 gives a latency of 14 cycles. IN_W=16 with random operands (≥1000) is checked against a software floor(sqrt) and rem.
